// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and helpers for the display scan path.
//   DIGIT_W            width of one BCD digit
//   BCD_BLANK_CODE     code that bcd_to_cathodes renders as an unlit digit
//   DEFAULT_NUM_DIGITS digit count of the combination-lock display
//   ptr_w(n)           width of an index that selects one of n digits

package display_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_BLANK_CODE = 4'hF;
  localparam int DEFAULT_NUM_DIGITS = 4;

  function automatic int ptr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/display_refresh_tick.sv
// display_refresh_tick
// Slot prescaler for the display scan.  Counts clock cycles within one digit
// slot and flags the last cycle of the slot.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   slot_tick out  1 on the last cycle of a slot (the next edge starts a new slot)
//   cnt_next  out  value the slot counter takes at the next edge; the scan
//                  mux registers its outputs from this so they line up with
//                  the counter state after the edge

module display_refresh_tick #(
  parameter int REFRESH_DIV = 50000,
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             slot_tick,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    slot_tick = (cnt == CNT_LAST);
    cnt_next  = slot_tick ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux
// Time-multiplexes the lock's code digits onto one shared 7-segment cathode
// bus.  Each slot selects one digit, drives its BCD value and pointer dot
// toward bcd_to_cathodes and pulls the matching anode low after a short
// all-off ghosting guard at the start of the slot.  Inputs are captured once
// per frame so a frame never shows a mix of old and new values.
// Ports:
//   clk                   in   system clock
//   rst_n                 in   asynchronous active-low reset
//   digits_in             in   packed BCD digits, digit i at [4i+3:4i], digit 0 leftmost
//   pointer_pos           in   index of the digit being edited
//   pointer_valid         in   1 = show the pointer dot at pointer_pos
//   digit                 out  BCD value of the active slot
//   position_pointer_now  out  1 = light the dot in the active slot
//   anode_n               out  active-low digit enables, anode_n[i] drives digit i
//   frame_start           out  one-cycle pulse on the first cycle of slot 0
// Build option:
//   DISPLAY_SCAN_MUX_POINTER_BLINK_EN  when defined, the pointer dot blinks
//   with a half-period of BLINK_DIV frames; otherwise it is steady.

module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_DIV    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [ptr_w(NUM_DIGITS)-1:0]  pointer_pos,
  input  logic                          pointer_valid,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          position_pointer_now,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic                          frame_start
);

  localparam int PTR_W = ptr_w(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic             slot_tick;
  logic [CNT_W-1:0] cnt_next;

  logic [PTR_W-1:0] idx, idx_nx;
  logic             frame_wrap;

  // Snapshot kept as one entry per digit; the packing matches digits_in.
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] snap_digits, snap_digits_nx;
  logic [PTR_W-1:0]                   snap_ptr, snap_ptr_nx;
  logic                               snap_ptr_v, snap_ptr_v_nx;

  logic [NUM_DIGITS-1:0] anode_nx;
  logic                  blink_gate;

  display_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_tick (slot_tick),
    .cnt_next  (cnt_next)
  );

  // Slot index advance and once-per-frame input capture.
  always_comb begin
    frame_wrap     = slot_tick && (idx == LAST_IDX);
    idx_nx         = idx;
    snap_digits_nx = snap_digits;
    snap_ptr_nx    = snap_ptr;
    snap_ptr_v_nx  = snap_ptr_v;
    if (slot_tick) begin
      idx_nx = frame_wrap ? '0 : idx + PTR_W'(1);
    end
    if (frame_wrap) begin
      snap_digits_nx = digits_in;
      snap_ptr_nx    = pointer_pos;
      snap_ptr_v_nx  = pointer_valid;
    end
  end

  // Only the active slot's anode goes low, and only once the guard window
  // has elapsed, so the cathodes settle before the digit lights.
  always_comb begin
    anode_nx = '1;
    if (cnt_next >= BLANK_END) begin
      anode_nx[idx_nx] = 1'b0;
    end
  end

`ifdef DISPLAY_SCAN_MUX_POINTER_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV);

  logic [BLINK_W-1:0] blink_cnt, blink_cnt_nx;
  logic               blink_phase, blink_phase_nx;

  // The first frame after reset only shows the reset snapshot and is not
  // counted; the phase then flips after every BLINK_DIV displayed frames.
  always_comb begin
    blink_cnt_nx   = blink_cnt;
    blink_phase_nx = blink_phase;
    if (frame_wrap) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nx   = BLINK_W'(1);
        blink_phase_nx = ~blink_phase;
      end else begin
        blink_cnt_nx = blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
    end
  end

  assign blink_gate = blink_phase_nx;
`else
  assign blink_gate = 1'b1;
`endif

  // Outputs are registered from next-state values so they describe the
  // slot the counter is in after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx                  <= '0;
      snap_digits          <= '0;
      snap_ptr             <= '0;
      snap_ptr_v           <= 1'b0;
      digit                <= '0;
      position_pointer_now <= 1'b0;
      anode_n              <= '1;
      frame_start          <= 1'b0;
    end else begin
      idx                  <= idx_nx;
      snap_digits          <= snap_digits_nx;
      snap_ptr             <= snap_ptr_nx;
      snap_ptr_v           <= snap_ptr_v_nx;
      digit                <= snap_digits_nx[idx_nx];
      position_pointer_now <= snap_ptr_v_nx && (snap_ptr_nx == idx_nx) && blink_gate;
      anode_n              <= anode_nx;
      frame_start          <= (idx_nx == '0) && (cnt_next == '0);
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux
// Directed bench for display_scan_mux with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, BLINK_DIV=2.  Expected slot contents for each frame are
// queued from the bench's own copy of the captured inputs and popped as the
// scan reaches each slot; anode timing and frame_start are checked every cycle.
// Honours DISPLAY_SCAN_MUX_POINTER_BLINK_EN for the dot expectation.

module tb_display_scan_mux;
  import display_pkg::*;

  localparam int NUM_DIGITS   = 4;
  localparam int REFRESH_DIV  = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_DIV    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [1:0]  pointer_pos;
  logic        pointer_valid;
  logic [3:0]  digit;
  logic        position_pointer_now;
  logic [3:0]  anode_n;
  logic        frame_start;

  typedef struct packed {
    logic [3:0] digit;
    logic       dot;
  } slot_exp_t;

  slot_exp_t sb[$];

  int total = 0;
  int bad = 0;
  int frame_no = 0;

  logic [15:0] tb_snap_digits;
  logic [1:0]  tb_snap_ptr;
  logic        tb_snap_v;

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_DIV    (BLINK_DIV)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .digits_in            (digits_in),
    .pointer_pos          (pointer_pos),
    .pointer_valid        (pointer_valid),
    .digit                (digit),
    .position_pointer_now (position_pointer_now),
    .anode_n              (anode_n),
    .frame_start          (frame_start)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] p, input logic v);
    digits_in     = d;
    pointer_pos   = p;
    pointer_valid = v;
  endtask

  // Dot phase by frame number since reset (frame 1 shows the reset snapshot).
  function automatic bit blinkOn(input int f);
`ifdef DISPLAY_SCAN_MUX_POINTER_BLINK_EN
    return (f <= 3) || ((((f - 4) / 2) % 2) == 1);
`else
    return (f >= 0);
`endif
  endfunction

  task automatic pushFrame();
    slot_exp_t e;
    frame_no++;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      e.digit = tb_snap_digits[s*4 +: 4];
      e.dot   = tb_snap_v && (int'(tb_snap_ptr) == s) && blinkOn(frame_no);
      sb.push_back(e);
    end
  endtask

  // Entered at the first cycle of a slot; checks ncyc cycles then leaves the
  // bench ncyc edges later.
  task automatic runSlot(input int slot, input int ncyc);
    slot_exp_t  e;
    logic [3:0] an_exp;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("[TB] FAIL sb_underflow f%0d s%0d: observed=empty expected=entry", frame_no, slot);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("f%0d s%0d digit", frame_no, slot), 32'(digit), 32'(e.digit));
          checkOutput($sformatf("f%0d s%0d dot", frame_no, slot), 32'(position_pointer_now), 32'(e.dot));
        end
      end
      an_exp = 4'hF;
      if (c >= BLANK_CYCLES) an_exp[slot] = 1'b0;
      checkOutput($sformatf("f%0d s%0d c%0d anode_n", frame_no, slot, c), 32'(anode_n), 32'(an_exp));
      checkOutput($sformatf("f%0d s%0d c%0d frame_start", frame_no, slot, c), 32'(frame_start),
                  32'((slot == 0) && (c == 0) && (frame_no >= 2)));
      tick();
    end
  endtask

  // One whole frame; optionally changes digits_in at the start of slot 1.
  task automatic runFrame(input logic mid_en, input logic [15:0] mid_digits);
    pushFrame();
    for (int s = 0; s < NUM_DIGITS; s++) begin
      if (s == 1 && mid_en) digits_in = mid_digits;
      runSlot(s, REFRESH_DIV);
    end
    tb_snap_digits = digits_in;
    tb_snap_ptr    = pointer_pos;
    tb_snap_v      = pointer_valid;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h7319, 2'd0, 1'b0);
    tb_snap_digits = '0;
    tb_snap_ptr    = '0;
    tb_snap_v      = 1'b0;
    repeat (2) tick();
    checkOutput("reset anode_n", 32'(anode_n), 32'h0000000F);
    checkOutput("reset digit", 32'(digit), 32'h0);
    checkOutput("reset dot", 32'(position_pointer_now), 32'h0);
    checkOutput("reset frame_start", 32'(frame_start), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    runFrame(1'b0, 16'h0);                       // frame 1: reset snapshot, zeros
    applyStimulus(16'h7319, 2'd2, 1'b1);
    runFrame(1'b0, 16'h0);                       // frame 2: 9,1,3,7, no dot
    runFrame(1'b1, 16'hA5C0);                    // frame 3: dot slot 2, mid-frame edit hidden
    applyStimulus(16'hA5C0, 2'd0, 1'b1);
    runFrame(1'b0, 16'h0);                       // frame 4: 0,C,5,A, dot slot 2
    runFrame(1'b0, 16'h0);                       // frames 5-7: dot slot 0
    runFrame(1'b0, 16'h0);
    runFrame(1'b0, 16'h0);

    // Frame 8: reset lands in the active part of slot 2.
    pushFrame();
    runSlot(0, REFRESH_DIV);
    runSlot(1, REFRESH_DIV);
    runSlot(2, 3);
    checkOutput("pre_reset anode_n", 32'(anode_n), 32'h0000000B);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async anode_n", 32'(anode_n), 32'h0000000F);
    checkOutput("async digit", 32'(digit), 32'h0);
    checkOutput("async dot", 32'(position_pointer_now), 32'h0);
    sb.delete();
    tick();
    @(negedge clk);
    rst_n          = 1'b1;
    frame_no       = 0;
    tb_snap_digits = '0;
    tb_snap_ptr    = '0;
    tb_snap_v      = 1'b0;
    runFrame(1'b0, 16'h0);                       // restart: zeros again
    runFrame(1'b0, 16'h0);                       // then A5C0 with dot slot 0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
